ysyx_041514_mem_databuff: RTL and testbench

Holding buffer beside the memory stage. It captures load data and fence.i completion that arrive while the memory stage is stalled by another part of the pipeline, and replays them until the instruction leaves the stage. Without it, a dcache/clint response that lands during an external stall would be lost, or the access would be issued twice. Its outputs drive the memory stage's `rdata_buff_valid_i`/`rdata_buff_i` and `mem_fencei_buff_valid_i`/`mem_fencei_ready_buff_i` inputs.

---
 rtl/ysyx_041514_mem_databuff.sv | 94 +++++++++
 tb/tb_ysyx_041514_mem_databuff.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041514_mem_databuff.sv
// Memory-stage holding buffer: keeps load data and fence.i completion
// that arrive during an external stall until the instruction leaves.
module ysyx_041514_mem_databuff #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_stall_i,
  input  logic            mem_flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            mem_data_ready_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            mem_fencei_ready_i,
  output logic            rdata_buff_valid_o,
  output logic [XLEN-1:0] rdata_buff_o,
  output logic            mem_fencei_buff_valid_o,
  output logic            mem_fencei_ready_buff_o,
  output logic [XLEN-1:0] buff_pc_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          d_state, d_next;
  state_t          f_state, f_next;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic            leave;
  logic            stale;
  logic            d_cap;
  logic            f_cap;

  always_comb begin
    leave  = ~mem_stall_i | mem_flush_i;
    stale  = pc_i != tag_q;
    d_cap  = mem_data_ready_i & mem_stall_i & ~mem_flush_i;
    f_cap  = mem_fencei_ready_i & mem_stall_i & ~mem_flush_i;
    d_next = d_state;
    f_next = f_state;
    data_d = data_q;
    tag_d  = tag_q;

    // Release beats capture; a response while FULL is never taken.
    unique case (d_state)
      EMPTY: begin
        if (d_cap) begin
          d_next = FULL;
          data_d = mem_data_i;
          tag_d  = pc_i;
        end
      end
      FULL: begin
        if (leave | stale) d_next = EMPTY;
      end
      default: d_next = EMPTY;
    endcase

    unique case (f_state)
      EMPTY: begin
        if (f_cap) begin
          f_next = FULL;
          tag_d  = pc_i;
        end
      end
      FULL: begin
        if (leave | stale) f_next = EMPTY;
      end
      default: f_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= EMPTY;
      f_state <= EMPTY;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      d_state <= d_next;
      f_state <= f_next;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign rdata_buff_valid_o      = d_state == FULL;
  assign rdata_buff_o            = data_q;
  assign mem_fencei_buff_valid_o = f_state == FULL;
  assign mem_fencei_ready_buff_o = f_state == FULL;
  assign buff_pc_o               = tag_q;

endmodule

// File: tb/tb_ysyx_041514_mem_databuff.sv
// Self-checking bench for ysyx_041514_mem_databuff: directed scenarios
// plus random traffic against an event-level reference model.
module tb_ysyx_041514_mem_databuff;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_stall_i;
  logic            mem_flush_i;
  logic [XLEN-1:0] pc_i;
  logic            mem_data_ready_i;
  logic [XLEN-1:0] mem_data_i;
  logic            mem_fencei_ready_i;
  logic            rdata_buff_valid_o;
  logic [XLEN-1:0] rdata_buff_o;
  logic            mem_fencei_buff_valid_o;
  logic            mem_fencei_ready_buff_o;
  logic [XLEN-1:0] buff_pc_o;

  int checks   = 0;
  int failures = 0;
  int conflicts = 0;

  bit              m_dv;
  bit              m_fv;
  logic [XLEN-1:0] m_data;
  logic [XLEN-1:0] m_tag;

  ysyx_041514_mem_databuff #(.XLEN(XLEN)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .mem_stall_i             (mem_stall_i),
    .mem_flush_i             (mem_flush_i),
    .pc_i                    (pc_i),
    .mem_data_ready_i        (mem_data_ready_i),
    .mem_data_i              (mem_data_i),
    .mem_fencei_ready_i      (mem_fencei_ready_i),
    .rdata_buff_valid_o      (rdata_buff_valid_o),
    .rdata_buff_o            (rdata_buff_o),
    .mem_fencei_buff_valid_o (mem_fencei_buff_valid_o),
    .mem_fencei_ready_buff_o (mem_fencei_ready_buff_o),
    .buff_pc_o               (buff_pc_o)
  );

  always #5 clk = ~clk;

  // Model: an entry survives only while its instruction stays put.
  function automatic void model_step();
    bit same_insn;
    bit took;
    if (rst) begin
      m_dv = 0; m_fv = 0; m_data = '0; m_tag = '0;
      return;
    end
    same_insn = mem_stall_i && !mem_flush_i && (pc_i == m_tag);
    took = 0;
    if (m_dv) begin
      if (mem_data_ready_i && same_insn) conflicts++;
      if (!same_insn) m_dv = 0;
    end else if (mem_data_ready_i && mem_stall_i && !mem_flush_i) begin
      m_dv = 1; m_data = mem_data_i; took = 1;
    end
    if (m_fv) begin
      if (!same_insn) m_fv = 0;
    end else if (mem_fencei_ready_i && mem_stall_i && !mem_flush_i) begin
      m_fv = 1; took = 1;
    end
    if (took) m_tag = pc_i;
  endfunction

  task automatic cycle(input bit r, input bit st, input bit fl,
                       input logic [XLEN-1:0] pc, input bit rdy,
                       input logic [XLEN-1:0] d, input bit frdy,
                       input string tag);
    rst = r; mem_stall_i = st; mem_flush_i = fl; pc_i = pc;
    mem_data_ready_i = rdy; mem_data_i = d; mem_fencei_ready_i = frdy;
    @(posedge clk);
    model_step();
    #1;
    checks++;
    if (rdata_buff_valid_o !== m_dv) begin
      failures++;
      $display("FAIL %s dvalid got=%b exp=%b", tag, rdata_buff_valid_o, m_dv);
    end
    checks++;
    if (rdata_buff_o !== m_data) begin
      failures++;
      $display("FAIL %s data got=%h exp=%h", tag, rdata_buff_o, m_data);
    end
    checks++;
    if (mem_fencei_buff_valid_o !== m_fv) begin
      failures++;
      $display("FAIL %s fvalid got=%b exp=%b", tag,
               mem_fencei_buff_valid_o, m_fv);
    end
    checks++;
    if (mem_fencei_ready_buff_o !== m_fv) begin
      failures++;
      $display("FAIL %s fready got=%b exp=%b", tag,
               mem_fencei_ready_buff_o, m_fv);
    end
    checks++;
    if (buff_pc_o !== m_tag) begin
      failures++;
      $display("FAIL %s tag got=%h exp=%h", tag, buff_pc_o, m_tag);
    end
  endtask

  task automatic idle(input logic [XLEN-1:0] pc, input string tag);
    cycle(0, 0, 0, pc, 0, '0, 0, tag);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, '0, 0, '0, 0, "reset");
    cycle(1, 1, 0, 64'h1234, 1, 64'hdead, 1, "reset_hold");
    checks++;
    if ({rdata_buff_valid_o, mem_fencei_buff_valid_o} !== 2'b00 ||
        rdata_buff_o !== '0 || buff_pc_o !== '0) begin
      failures++;
      $display("FAIL reset_const got=%b%b %h %h exp=00 0 0",
               rdata_buff_valid_o, mem_fencei_buff_valid_o,
               rdata_buff_o, buff_pc_o);
    end
  endtask

  task automatic test_capture_release();
    logic [XLEN-1:0] pc = 64'h8000_0010;
    logic [XLEN-1:0] d  = 64'hFFFF_FFFF_FFFF_FF80;
    cycle(0, 1, 0, pc, 1, d, 0, "cap_c1");
    cycle(0, 1, 0, pc, 0, '0, 0, "cap_c2");
    cycle(0, 1, 0, pc, 0, '0, 0, "cap_c3");
    checks++;
    if (rdata_buff_valid_o !== 1'b1 || rdata_buff_o !== d ||
        buff_pc_o !== pc) begin
      failures++;
      $display("FAIL cap_const got=%b %h %h exp=1 %h %h",
               rdata_buff_valid_o, rdata_buff_o, buff_pc_o, d, pc);
    end
    cycle(0, 0, 0, pc, 0, '0, 0, "cap_c4_leave");
    checks++;
    if (rdata_buff_valid_o !== 1'b0 || rdata_buff_o !== d) begin
      failures++;
      $display("FAIL rel_const got=%b %h exp=0 %h",
               rdata_buff_valid_o, rdata_buff_o, d);
    end
  endtask

  task automatic test_nostall();
    cycle(0, 0, 0, 64'h8000_0040, 1, 64'h55, 1, "nostall");
    checks++;
    if (rdata_buff_valid_o !== 1'b0 || buff_pc_o !== 64'h8000_0010) begin
      failures++;
      $display("FAIL nostall_const got=%b %h exp=0 80000010",
               rdata_buff_valid_o, buff_pc_o);
    end
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] pc = 64'h8000_0100;
    cycle(0, 1, 0, pc, 1, 64'h77, 0, "fl_cap");
    cycle(0, 1, 0, pc, 0, '0, 0, "fl_hold");
    cycle(0, 1, 1, pc, 0, '0, 0, "fl_kill");
    cycle(0, 1, 1, pc, 1, 64'h99, 1, "fl_nocap");
    checks++;
    if (rdata_buff_valid_o !== 1'b0 || mem_fencei_buff_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_const got=%b%b exp=00",
               rdata_buff_valid_o, mem_fencei_buff_valid_o);
    end
    idle(pc, "fl_idle");
  endtask

  task automatic test_pc_mismatch();
    cycle(0, 1, 0, 64'h8000_0010, 1, 64'hAB, 0, "pc_cap");
    cycle(0, 1, 0, 64'h8000_0020, 0, '0, 0, "pc_stale");
    checks++;
    if (rdata_buff_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL pc_stale_const got=%b exp=0", rdata_buff_valid_o);
    end
    idle(64'h8000_0020, "pc_idle");
  endtask

  task automatic test_fencei();
    logic [XLEN-1:0] pc = 64'h8000_0200;
    cycle(0, 1, 0, pc, 0, '0, 1, "fi_cap");
    checks++;
    if (mem_fencei_buff_valid_o !== 1'b1 || mem_fencei_ready_buff_o !== 1'b1 ||
        rdata_buff_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL fi_const got=%b%b%b exp=110", mem_fencei_buff_valid_o,
               mem_fencei_ready_buff_o, rdata_buff_valid_o);
    end
    cycle(0, 1, 0, pc, 1, 64'h1111, 0, "fi_then_load");
    idle(pc, "fi_rel");
    cycle(0, 1, 0, pc + 8, 1, 64'h2222, 1, "both_cap");
    cycle(0, 1, 0, pc + 8, 0, '0, 0, "both_hold");
  endtask

  task automatic test_reset_full();
    cycle(1, 1, 0, 64'h8000_0208, 1, 64'h3333, 1, "rst_full");
    checks++;
    if (rdata_buff_valid_o !== 1'b0 || mem_fencei_buff_valid_o !== 1'b0 ||
        mem_fencei_ready_buff_o !== 1'b0 || rdata_buff_o !== '0 ||
        buff_pc_o !== '0) begin
      failures++;
      $display("FAIL rst_full_const got=%b%b%b %h %h exp=000 0 0",
               rdata_buff_valid_o, mem_fencei_buff_valid_o,
               mem_fencei_ready_buff_o, rdata_buff_o, buff_pc_o);
    end
    cycle(0, 1, 0, 64'h8000_0208, 0, '0, 0, "rst_rel1");
    cycle(0, 1, 0, 64'h8000_0208, 0, '0, 0, "rst_rel2");
  endtask

  task automatic test_random();
    logic [XLEN-1:0] pcs [4];
    logic [XLEN-1:0] pc;
    pcs[0] = 64'h8000_0000; pcs[1] = 64'h8000_0004;
    pcs[2] = 64'h8000_0008; pcs[3] = 64'h8000_0010;
    pc = pcs[0];
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) pc = pcs[$urandom_range(0, 3)];
      cycle($urandom_range(0, 60) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 12) == 0,
            pc,
            $urandom_range(0, 2) == 0,
            {$urandom, $urandom},
            $urandom_range(0, 5) == 0,
            "random");
    end
  endtask

  initial begin
    rst = 1; mem_stall_i = 0; mem_flush_i = 0; pc_i = '0;
    mem_data_ready_i = 0; mem_data_i = '0; mem_fencei_ready_i = 0;
    m_dv = 0; m_fv = 0; m_data = '0; m_tag = '0;
    test_reset();
    test_capture_release();
    test_nostall();
    test_flush();
    test_pc_mismatch();
    test_fencei();
    test_reset_full();
    test_random();
    $display("note: responses while held (dropped) = %0d", conflicts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
